// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for lock with timeout/retry, qualifies stable lock before releasing sys_rst.
// Latency: locked -> decision 2 cycles (sync) + 1; RUN entered LOCK_STABLE_CYCLES cycles after STABLE entry.
// Backpressure: none; optional RUN lock-loss glitch filter via PLL_SUP_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20,
    parameter int RETRY_W             = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         lock_lost_count
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lock_sync;
    logic             locked_s;
    logic             lock_loss;

    assign locked_s = lock_sync[1];

`ifdef PLL_SUP_GLITCH_FILTER_EN
    // Loss is acted on in the 4th consecutive low cycle of locked_s.
    logic [1:0] glitch_cnt;
    assign lock_loss = !locked_s && (glitch_cnt == 2'd3);
`else
    assign lock_loss = !locked_s;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state           <= ST_RESET_PLL;
            cnt             <= '0;
            lock_sync       <= 2'b00;
            retry_count     <= '0;
            lock_lost_count <= 8'd0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
            glitch_cnt      <= 2'd0;
`endif
        end else begin
            lock_sync <= {lock_sync[0], locked};
            if (force_relock && state != ST_RESET_PLL) begin
                state       <= ST_RESET_PLL;
                cnt         <= '0;
                retry_count <= '0;
            end else begin
                case (state)
                    ST_RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state <= ST_WAIT_LOCK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt <= '0;
                            if (retry_count == RETRY_MAX) begin
                                state <= ST_FAIL;
                            end else begin
                                retry_count <= retry_count + 1'b1;
                                state       <= ST_RESET_PLL;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STABLE: begin
                        if (!locked_s) begin
                            state <= ST_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state       <= ST_RUN;
                            cnt         <= '0;
                            retry_count <= '0;
`ifdef PLL_SUP_GLITCH_FILTER_EN
                            glitch_cnt  <= 2'd0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (lock_loss) begin
                            state       <= ST_RESET_PLL;
                            cnt         <= '0;
                            retry_count <= '0;
                            if (lock_lost_count != 8'hFF) begin
                                lock_lost_count <= lock_lost_count + 8'd1;
                            end
                        end
`ifdef PLL_SUP_GLITCH_FILTER_EN
                        if (locked_s) begin
                            glitch_cnt <= 2'd0;
                        end else if (!lock_loss) begin
                            glitch_cnt <= glitch_cnt + 2'd1;
                        end
`endif
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state <= ST_RESET_PLL;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_rst = (state == ST_RESET_PLL);
    assign sys_rst = (state != ST_RUN);
    assign ready   = (state == ST_RUN);
    assign fail    = (state == ST_FAIL);

endmodule
